// File: rtl/gmii_rx.sv
// GMII receive front end: strips preamble/SFD and pushes {1,byte} / {0,status} words to the RX FIFO.
// Optional CRC-32 frame check is enabled by defining RX_FCS_CHECK_EN.
module gmii_rx #(
    parameter int unsigned MAX_LEN = 1518,
    parameter int unsigned MIN_LEN = 64
) (
    input  logic        phy_rx_clk,
    input  logic        sys_rst_n,
    input  logic        phy_rx_dv,
    input  logic        phy_rx_er,
    input  logic [7:0]  phy_rxd,
    input  logic        fifo_full,
    output logic        wr_en,
    output logic [8:0]  wr_data,
    output logic [15:0] rx_frame_cnt,
    output logic [15:0] rx_err_cnt
);
    localparam int unsigned CntW = $clog2(MAX_LEN + 1);

    typedef enum logic [1:0] {StIdle, StPream, StData, StDrop} state_e;

    logic [1:0]      rst_sync_q;
    logic            rst_int_n;
    state_e          state_q;
    logic            dv_q, er_q, full_q;
    logic [7:0]      rxd_q;
    logic [CntW-1:0] cnt_q;
    logic            pend_q, ovf_q;
    logic [4:0]      pend_status_q;
    logic            wr_en_q;
    logic [8:0]      wr_data_q;
    logic [15:0]     frame_cnt_q, err_cnt_q;

    logic            in_data, at_max, sfd_hit, flush, hold, data_wr, data_end, direct_eof, eof_wr;
    logic            fcs_ok, err_hit;
    logic [4:0]      end_status, eof_status;

    // Assert asynchronously, release synchronously to phy_rx_clk.
    always_ff @(posedge phy_rx_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            rst_sync_q <= 2'b00;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end
    assign rst_int_n = rst_sync_q[1];

    assign in_data    = (state_q == StData);
    assign at_max     = (cnt_q == CntW'(MAX_LEN));
    assign sfd_hit    = (state_q == StPream) && dv_q && (rxd_q == 8'hD5);
    assign flush      = pend_q && !full_q;
    // A pending end word that cannot drain yet keeps the frame open so it never needs a second slot.
    assign hold       = in_data && pend_q && full_q;
    assign data_wr    = in_data && !hold && dv_q && !er_q && !full_q && !pend_q && !ovf_q && !at_max;
    assign data_end   = in_data && !hold && !data_wr;
    assign direct_eof = data_end && !full_q && !pend_q;
    assign eof_wr     = flush || direct_eof;
    assign eof_status = flush ? pend_status_q : end_status;

    always_comb begin
        end_status = '0;
        if (!dv_q) begin
            end_status[4] = (cnt_q < CntW'(MIN_LEN));
            end_status[2] = ovf_q;
            end_status[0] = fcs_ok && !ovf_q;
        end else if (er_q) begin
            end_status[1] = 1'b1;
        end else if (full_q || pend_q || ovf_q) begin
            end_status[2] = 1'b1;
        end else begin
            end_status[3] = 1'b1;
        end
    end

`ifdef RX_FCS_CHECK_EN
    logic [31:0] crc_q, crc_rev;

    function automatic logic [31:0] crc_byte(input logic [31:0] crc, input logic [7:0] data);
        logic [31:0] c;
        c = crc;
        for (int i = 0; i < 8; i++) begin
            c = (c >> 1) ^ ((c[0] ^ data[i]) ? 32'hEDB88320 : 32'h0000_0000);
        end
        return c;
    endfunction

    // Residue is defined on the MSB-first register, so compare the bit-reversed value.
    assign crc_rev = {<<{crc_q}};
    assign fcs_ok  = (crc_rev == 32'hC704DD7B);
    assign err_hit = (|eof_status[4:1]) || !eof_status[0];

    always_ff @(posedge phy_rx_clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            crc_q <= '1;
        end else if (sfd_hit) begin
            crc_q <= '1;
        end else if (data_wr) begin
            crc_q <= crc_byte(crc_q, rxd_q);
        end
    end
`else
    assign fcs_ok  = 1'b0;
    assign err_hit = |eof_status[4:1];
`endif

    always_ff @(posedge phy_rx_clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            state_q       <= StIdle;
            dv_q          <= 1'b0;
            er_q          <= 1'b0;
            full_q        <= 1'b0;
            rxd_q         <= 8'h00;
            cnt_q         <= '0;
            pend_q        <= 1'b0;
            ovf_q         <= 1'b0;
            pend_status_q <= 5'h00;
            wr_en_q       <= 1'b0;
            wr_data_q     <= 9'h000;
            frame_cnt_q   <= 16'h0000;
            err_cnt_q     <= 16'h0000;
        end else begin
            dv_q    <= phy_rx_dv;
            er_q    <= phy_rx_er;
            full_q  <= fifo_full;
            rxd_q   <= phy_rxd;
            wr_en_q <= eof_wr || data_wr;
            if (eof_wr) begin
                wr_data_q   <= {4'b0000, eof_status};
                frame_cnt_q <= frame_cnt_q + 16'd1;
                if (err_hit) begin
                    err_cnt_q <= err_cnt_q + 16'd1;
                end
            end else if (data_wr) begin
                wr_data_q <= {1'b1, rxd_q};
            end
            if (flush) begin
                pend_q <= 1'b0;
            end
            if (data_end && (full_q || pend_q)) begin
                pend_q        <= 1'b1;
                pend_status_q <= end_status;
            end
            unique case (state_q)
                StIdle: begin
                    if (dv_q) begin
                        state_q <= (rxd_q == 8'h55) ? StPream : StDrop;
                    end
                end
                StPream: begin
                    if (!dv_q) begin
                        state_q <= StIdle;
                    end else if (sfd_hit) begin
                        state_q <= StData;
                        cnt_q   <= '0;
                        ovf_q   <= 1'b0;
                    end else if (rxd_q != 8'h55) begin
                        state_q <= StDrop;
                    end
                end
                StData: begin
                    if (hold) begin
                        ovf_q <= 1'b1;
                    end else if (data_wr) begin
                        cnt_q <= cnt_q + CntW'(1);
                    end else begin
                        state_q <= dv_q ? StDrop : StIdle;
                    end
                end
                StDrop: begin
                    if (!dv_q) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign wr_en        = wr_en_q;
    assign wr_data      = wr_data_q;
    assign rx_frame_cnt = frame_cnt_q;
    assign rx_err_cnt   = err_cnt_q;
endmodule

// File: tb/tb_gmii_rx.sv
// Scoreboard bench for gmii_rx: a frame-level reference model queues expected FIFO words,
// and a monitor pops and compares them whenever the DUT writes.
module tb_gmii_rx;
    localparam int MaxLen = 1518;
    localparam int MinLen = 64;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        dv    = 1'b0;
    logic        er    = 1'b0;
    logic        full  = 1'b0;
    logic [7:0]  rxd   = 8'h00;
    logic        wr_en;
    logic [8:0]  wr_data;
    logic [15:0] frame_cnt, err_cnt;

    gmii_rx #(.MAX_LEN(MaxLen), .MIN_LEN(MinLen)) dut (
        .phy_rx_clk   (clk),
        .sys_rst_n    (rst_n),
        .phy_rx_dv    (dv),
        .phy_rx_er    (er),
        .phy_rxd      (rxd),
        .fifo_full    (full),
        .wr_en        (wr_en),
        .wr_data      (wr_data),
        .rx_frame_cnt (frame_cnt),
        .rx_err_cnt   (err_cnt)
    );

    always #4 clk = ~clk;

    typedef struct packed {logic dv; logic er; logic full; logic [7:0] d;} cyc_t;
    typedef struct packed {logic [1:0] kind; logic [15:0] f; logic [15:0] e;} chk_t;

    cyc_t        stim[$];
    logic [8:0]  exp_q[$];
    chk_t        chk_q[$];
    int          n_chk  = 0;
    int          n_fail = 0;
    logic [15:0] m_frames = 16'h0;
    logic [15:0] m_errs   = 16'h0;

    function automatic logic [31:0] crc32(input logic [7:0] q[$], input int n);
        logic [31:0] c = 32'hFFFFFFFF;
        for (int k = 0; k < n; k++) begin
            c = c ^ {24'h0, q[k]};
            for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        end
        return c;
    endfunction

`ifdef RX_FCS_CHECK_EN
    function automatic bit fcs_good(input logic [7:0] q[$]);
        logic [31:0] f;
        int n = q.size();
        if (n < 4) return 1'b0;
        f = ~crc32(q, n - 4);
        return (q[n-4] == f[7:0]) && (q[n-3] == f[15:8]) && (q[n-2] == f[23:16])
            && (q[n-1] == f[31:24]);
    endfunction
`endif

    task automatic put(input logic v, input logic e, input logic [7:0] d);
        cyc_t c;
        c.dv = v; c.er = e; c.full = 1'b0; c.d = d;
        stim.push_back(c);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) put(1'b0, 1'b0, 8'h00);
    endtask

    task automatic set_er(input int j);
        cyc_t c;
        c = stim[j]; c.er = 1'b1; stim[j] = c;
    endtask

    task automatic set_full(input int from, input int n);
        cyc_t c;
        for (int j = from; j < from + n && j < stim.size(); j++) begin
            c = stim[j]; c.full = 1'b1; stim[j] = c;
        end
    endtask

    // Preamble, SFD, then len bytes whose last four are a correct FCS (unless corrupted).
    task automatic add_frame(input int npre, input int len, input bit corrupt, output int dstart);
        logic [7:0]  p[$];
        logic [31:0] c;
        int          j;
        for (int k = 0; k < npre; k++) put(1'b1, 1'b0, 8'h55);
        put(1'b1, 1'b0, 8'hD5);
        dstart = stim.size();
        if (len >= 4) begin
            for (int k = 0; k < len - 4; k++) p.push_back(8'($urandom));
            c = ~crc32(p, len - 4);
            p.push_back(c[7:0]); p.push_back(c[15:8]); p.push_back(c[23:16]); p.push_back(c[31:24]);
        end else begin
            for (int k = 0; k < len; k++) p.push_back(8'($urandom));
        end
        if (corrupt && len > 4) begin
            j = $urandom_range(0, len - 5);
            p[j] = p[j] ^ 8'h01;
        end
        for (int k = 0; k < len; k++) put(1'b1, 1'b0, p[k]);
    endtask

    // Frame-level reference: parse the stimulus and derive the words and counter effects.
    task automatic model();
        int         i = 0;
        int         n = 0;
        logic [4:0] st = 5'h00;
        bit         ab = 1'b0;
        logic [7:0] got[$];
        while (i < stim.size() && stim[i].dv && stim[i].d == 8'h55) i++;
        if (i == 0 || i >= stim.size() || !stim[i].dv || stim[i].d != 8'hD5) return;
        i++;
        while (i < stim.size() && stim[i].dv) begin
            if (stim[i].er)       begin st = 5'h02; ab = 1'b1; break; end
            if (stim[i].full)     begin st = 5'h04; ab = 1'b1; break; end
            if (n == MaxLen)      begin st = 5'h08; ab = 1'b1; break; end
            exp_q.push_back({1'b1, stim[i].d});
            got.push_back(stim[i].d);
            n++;
            i++;
        end
        if (!ab) begin
            if (n < MinLen) st[4] = 1'b1;
`ifdef RX_FCS_CHECK_EN
            st[0] = fcs_good(got);
`endif
        end
        exp_q.push_back({4'b0000, st});
        m_frames = m_frames + 16'd1;
`ifdef RX_FCS_CHECK_EN
        if ((|st[4:1]) || !st[0]) m_errs = m_errs + 16'd1;
`else
        if (|st[4:1]) m_errs = m_errs + 16'd1;
`endif
    endtask

    task automatic post(input logic [1:0] kind);
        chk_t c;
        c.kind = kind; c.f = m_frames; c.e = m_errs;
        chk_q.push_back(c);
    endtask

    // upto < 0 plays the whole stimulus; otherwise reset is asserted after 'upto' cycles.
    task automatic run(input int upto);
        int lim;
        lim = (upto < 0) ? stim.size() : upto;
        model();
        for (int k = 0; k < lim; k++) begin
            @(posedge clk); #1;
            dv = stim[k].dv; er = stim[k].er; full = stim[k].full; rxd = stim[k].d;
        end
        stim.delete();
        if (upto >= 0) begin
            @(posedge clk); #1;
            rst_n = 1'b0;
            post(2'd1);
            dv = 1'b0; er = 1'b0; full = 1'b0; rxd = 8'h00;
            m_frames = 16'h0; m_errs = 16'h0;
            repeat (4) @(posedge clk);
            #1 rst_n = 1'b1;
            repeat (5) @(posedge clk);
            #1 post(2'd1);
            repeat (2) @(posedge clk);
        end else begin
            @(posedge clk); #1;
            dv = 1'b0; er = 1'b0; full = 1'b0; rxd = 8'h00;
            repeat (6) @(posedge clk);
            #1 post(2'd0);
            repeat (2) @(posedge clk);
        end
    endtask

    always @(negedge clk) begin
        logic [8:0] w;
        chk_t       c;
        if (rst_n && wr_en) begin
            n_chk++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL word: unexpected write %h, required no write", wr_data);
            end else begin
                w = exp_q.pop_front();
                if (wr_data !== w) begin
                    n_fail++;
                    $display("FAIL word: got %h, required %h", wr_data, w);
                end
            end
        end
        if (chk_q.size() != 0) begin
            c = chk_q.pop_front();
            if (c.kind == 2'd0) begin
                n_chk++;
                if (frame_cnt !== c.f) begin
                    n_fail++;
                    $display("FAIL frame_cnt: got %0d, required %0d", frame_cnt, c.f);
                end
                n_chk++;
                if (err_cnt !== c.e) begin
                    n_fail++;
                    $display("FAIL err_cnt: got %0d, required %0d", err_cnt, c.e);
                end
                n_chk++;
                if (exp_q.size() != 0) begin
                    n_fail++;
                    $display("FAIL drain: %0d words still outstanding, required 0", exp_q.size());
                    exp_q.delete();
                end
            end else begin
                n_chk++;
                if (wr_en !== 1'b0) begin
                    n_fail++;
                    $display("FAIL reset wr_en: got %b, required 0", wr_en);
                end
                n_chk++;
                if (wr_data !== 9'h000) begin
                    n_fail++;
                    $display("FAIL reset wr_data: got %h, required 000", wr_data);
                end
                n_chk++;
                if (frame_cnt !== 16'h0 || err_cnt !== 16'h0) begin
                    n_fail++;
                    $display("FAIL reset counters: got %0d/%0d, required 0/0", frame_cnt, err_cnt);
                end
                exp_q.delete();
            end
        end
    end

    initial begin
        int ds, npre, len, mode, j;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 post(2'd1);
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (5) @(posedge clk);

        // Valid 64-byte frame with long preamble.
        add_frame(7, 64, 1'b0, ds); idle(10); run(-1);
        // Corrupted payload byte.
        add_frame(7, 64, 1'b1, ds); idle(10); run(-1);
        // Receive error on data byte 10.
        add_frame(7, 64, 1'b0, ds); set_er(ds + 9); idle(10); run(-1);
        // FIFO full from data byte 20 for 50 cycles.
        add_frame(7, 64, 1'b0, ds); idle(60); set_full(ds + 19, 50); run(-1);
        // Preamble without SFD, then a frame starting with a non-preamble byte.
        for (int k = 0; k < 3; k++) put(1'b1, 1'b0, 8'h55);
        idle(8); run(-1);
        put(1'b1, 1'b0, 8'h00);
        for (int k = 0; k < 10; k++) put(1'b1, 1'b0, 8'($urandom));
        idle(8); run(-1);
        // Giant frame.
        add_frame(7, 1600, 1'b0, ds); idle(10); run(-1);
        // Short frames at the runt boundary.
        add_frame(2, MinLen - 1, 1'b0, ds); idle(10); run(-1);
        add_frame(1, 0, 1'b0, ds); idle(10); run(-1);

        for (int f = 0; f < 40; f++) begin
            npre = $urandom_range(1, 7);
            case ($urandom_range(0, 2))
                0:       len = $urandom_range(0, 10);
                1:       len = $urandom_range(MinLen - 6, MinLen + 6);
                default: len = $urandom_range(100, 300);
            endcase
            add_frame(npre, len, ($urandom_range(0, 3) == 0), ds);
            idle(40);
            mode = $urandom_range(0, 9);
            if (mode == 0 && len > 0) begin
                set_er(ds + $urandom_range(0, len - 1));
            end else if ((mode == 1 || mode == 2) && len > 0) begin
                set_full(ds + $urandom_range(0, len), $urandom_range(1, 20));
            end else if (mode == 3) begin
                j = $urandom_range(0, 255);
                if (j == 8'h55) j = 0;
                stim[0] = {1'b1, 1'b0, 1'b0, 8'(j)};
            end else if (mode == 4) begin
                stim[npre] = {1'b1, 1'b0, 1'b0, 8'hAA};
            end
            run(-1);
        end

        // Reset in the middle of data, then a clean frame afterwards.
        add_frame(7, 100, 1'b0, ds); idle(10); run(ds + 40);
        add_frame(7, 64, 1'b0, ds); idle(10); run(-1);

        repeat (4) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
